// File: rtl/intrapred_pkg.sv
// Shared widths, FSM state type and intra mode tags for the intra-prediction datapath.
// Also holds the residual sign-extension helper used by the transform.
package intrapred_pkg;

    localparam int RES_W   = 9;
    localparam int COEF_W  = 16;
    localparam int MODE_W  = 4;
    localparam int MBNUM_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROW  = 2'd1,
        ST_COL  = 2'd2,
        ST_DONE = 2'd3
    } xform_state_t;

    // Values carried on the mode tag; the transform passes them through without interpreting them.
    typedef enum logic [MODE_W-1:0] {
        MODE_I4_VERT   = 4'd0,
        MODE_I4_HORZ   = 4'd1,
        MODE_I4_DC     = 4'd2,
        MODE_I4_DDL    = 4'd3,
        MODE_I4_DDR    = 4'd4,
        MODE_I4_VR     = 4'd5,
        MODE_I4_HD     = 4'd6,
        MODE_I4_VL     = 4'd7,
        MODE_I4_HU     = 4'd8
    } intra_mode_t;

    function automatic logic [COEF_W-1:0] sext_res(input logic [RES_W-1:0] v);
        return {{(COEF_W-RES_W){v[RES_W-1]}}, v};
    endfunction

endpackage

// File: rtl/core_butterfly4.sv
// Combinational 1-D H.264 forward core transform on four COEF_W-bit two's complement values.
// Wraps modulo 2^COEF_W; the caller guarantees the range never needs more bits.
module core_butterfly4
    import intrapred_pkg::*;
(
    input  logic [3:0][COEF_W-1:0] x,
    output logic [3:0][COEF_W-1:0] y
);

    logic [COEF_W-1:0] s0, s1, d0, d1;

    assign s0 = x[0] + x[3];
    assign s1 = x[1] + x[2];
    assign d0 = x[0] - x[3];
    assign d1 = x[1] - x[2];

    assign y[0] = s0 + s1;
    assign y[1] = {d0[COEF_W-2:0], 1'b0} + d1;
    assign y[2] = s0 - s1;
    assign y[3] = d0 - {d1[COEF_W-2:0], 1'b0};

endmodule

// File: rtl/core_transform4x4.sv
// Forward 4x4 integer core transform Y = Cf*X*Cf^T: four row passes into T, then four column passes
// into the output register, all through one shared butterfly.
module core_transform4x4
    import intrapred_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [16*RES_W-1:0]       in_res,
    input  logic [MODE_W-1:0]         in_mode,
    input  logic [MBNUM_W-1:0]        in_mbnumber,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [16*COEF_W-1:0]      out_coef,
    output logic [MODE_W-1:0]         out_mode,
    output logic [MBNUM_W-1:0]        out_mbnumber
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high; valid never
    // depends on ready, and data/tags stay stable while valid is high and ready is low.

    xform_state_t state, state_nx;
    logic [1:0]   cnt;
    logic         accept;

    logic [3:0][3:0][RES_W-1:0]  x_q;
    logic [3:0][3:0][COEF_W-1:0] t_q;
    logic [3:0][3:0][COEF_W-1:0] y_q;
    logic [MODE_W-1:0]           mode_q;
    logic [MBNUM_W-1:0]          mb_q;

    logic [3:0][COEF_W-1:0] bf_in, bf_out;

    assign accept   = in_valid && in_ready;
    assign out_coef = y_q;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ST_ROW;
            end
            ST_ROW: begin
                if (cnt == 2'd3) state_nx = ST_COL;
            end
            ST_COL: begin
                if (cnt == 2'd3) state_nx = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nx = in_valid ? ST_ROW : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Row passes read row cnt of X; column passes read column cnt of T.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bf_in[i] = (state == ST_COL) ? t_q[i][cnt] : sext_res(x_q[cnt][i]);
        end
    end

    core_butterfly4 u_butterfly (
        .x (bf_in),
        .y (bf_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= 2'd0;
            x_q          <= '0;
            t_q          <= '0;
            y_q          <= '0;
            mode_q       <= '0;
            mb_q         <= '0;
            out_mode     <= '0;
            out_mbnumber <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                x_q    <= in_res;
                mode_q <= in_mode;
                mb_q   <= in_mbnumber;
                cnt    <= 2'd0;
            end
            if (state == ST_ROW) begin
                t_q[cnt] <= bf_out;
                cnt      <= cnt + 2'd1;
            end
            if (state == ST_COL) begin
                for (int r = 0; r < 4; r++) begin
                    y_q[r][cnt] <= bf_out[r];
                end
                cnt <= cnt + 2'd1;
                // Tags move to the output together with the final column so they match the block shown.
                if (cnt == 2'd3) begin
                    out_mode     <= mode_q;
                    out_mbnumber <= mb_q;
                end
            end
        end
    end

endmodule
